// File: rtl/nn_weight_init.sv
// Weight-memory initialiser: draws one LFSR byte per weight, centres and scales it
// into a signed fixed-point word, and writes it through a ready/enable port.
module nn_weight_init #(
  parameter int NUM_WEIGHTS = 64,
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 16,
  parameter int SCALE_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  output logic              o_rnd_read,
  input  logic [31:0]       i_rnd_data,
  output logic              o_wr_en,
  input  logic              i_wr_ready,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WEIGHTS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_CAP   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] w_next_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] w_next_data;
  logic              r_rnd_read;
  logic              r_wr_en;
  logic              r_busy;
  logic              r_done;
  logic              w_last;
  logic [23:0]       w_unused_rnd_hi;

  // Only the low byte of the source word carries randomness.
  assign w_unused_rnd_hi = i_rnd_data[31:8];
  assign w_last          = (r_wr_addr == LAST_ADDR);

  // Inverting bit 7 is r-128 as a signed byte; then sign-extend and scale.
  function automatic logic [DATA_W-1:0] f_map_weight(input logic [7:0] i_byte);
    logic signed [7:0]        v_centred;
    logic signed [DATA_W-1:0] v_ext;
    v_centred = $signed({~i_byte[7], i_byte[6:0]});
    v_ext     = DATA_W'(v_centred);
    return v_ext <<< SCALE_SHIFT;
  endfunction

  // Next-state, next-address and next-data decode.
  always_comb begin
    w_next_state = r_state;
    w_next_addr  = r_wr_addr;
    w_next_data  = r_wr_data;
    case (r_state)
      S_IDLE: begin
        w_next_addr = {ADDR_W{1'b0}};
        if (i_start) begin
          w_next_state = S_REQ;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_REQ: begin
        w_next_state = S_CAP;
      end
      S_CAP: begin
        w_next_state = S_WRITE;
        w_next_data  = f_map_weight(i_rnd_data[7:0]);
      end
      S_WRITE: begin
        if (i_wr_ready) begin
          if (w_last) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_REQ;
            w_next_addr  = r_wr_addr + ADDR_W'(1'b1);
          end
        end else begin
          w_next_state = S_WRITE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
        w_next_addr  = {ADDR_W{1'b0}};
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_addr  = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State and registered Moore outputs, decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wr_addr  <= {ADDR_W{1'b0}};
      r_wr_data  <= {DATA_W{1'b0}};
      r_rnd_read <= 1'b0;
      r_wr_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wr_addr  <= w_next_addr;
      r_wr_data  <= w_next_data;
      r_rnd_read <= (w_next_state == S_REQ);
      r_wr_en    <= (w_next_state == S_WRITE);
      r_busy     <= (w_next_state != S_IDLE);
      r_done     <= (w_next_state == S_DONE);
    end
  end

  assign o_rnd_read = r_rnd_read;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_nn_weight_init.sv
// Bench for nn_weight_init: two instances (4 weights unscaled, 64 weights scaled)
// fed by table/LFSR byte sources and checked against an arithmetic weight model.
module tb_nn_weight_init;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s    [2];
  logic        rnd_read_s [2];
  logic [31:0] rnd_data_s [2];
  logic        wr_en_s    [2];
  logic        wr_ready_s [2];
  logic [5:0]  wr_addr_s  [2];
  logic [15:0] wr_data_s  [2];
  logic        busy_s     [2];
  logic        done_s     [2];

  logic [7:0]  src_mem  [2][256];
  int          src_idx  [2] = '{0, 0};
  int          rd_cnt   [2] = '{0, 0};
  int          wr_cnt   [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  logic [15:0] wlog     [2][64];

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input int g, input string nm);
    chk(nm, {6'd0, rnd_read_s[g], wr_en_s[g], wr_addr_s[g], wr_data_s[g], busy_s[g], done_s[g]}, 32'd0);
  endtask

  // Weight value from the rules: (byte - 128) * 2^shift, kept to 16 bits.
  function automatic logic [15:0] f_model(input logic [7:0] b, input int ss);
    int v;
    v = (int'(b) - 128) * (1 << ss);
    return v[15:0];
  endfunction

  function automatic logic [7:0] f_lfsr_next(input logic [7:0] b);
    return {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int NW = (g == 0) ? 4 : 64;
    localparam int SS = (g == 0) ? 0 : 4;
    logic [7:0] byte_q[$];
    int         exp_addr = 0;

    nn_weight_init #(
      .NUM_WEIGHTS(NW), .ADDR_W(6), .DATA_W(16), .SCALE_SHIFT(SS)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .i_start(start_s[g]),
      .o_rnd_read(rnd_read_s[g]), .i_rnd_data(rnd_data_s[g]),
      .o_wr_en(wr_en_s[g]), .i_wr_ready(wr_ready_s[g]),
      .o_wr_addr(wr_addr_s[g]), .o_wr_data(wr_data_s[g]),
      .o_busy(busy_s[g]), .o_done(done_s[g])
    );

    // Random source: registers the next byte on the edge ending a read strobe.
    always @(posedge clk) begin
      if (rnd_read_s[g]) begin
        rnd_data_s[g] <= {24'hABCDEF, src_mem[g][src_idx[g]]};
        byte_q.push_back(src_mem[g][src_idx[g]]);
        src_idx[g]    <= src_idx[g] + 1;
        rd_cnt[g]     <= rd_cnt[g] + 1;
      end
    end

    // Compare process: every presented write against the model's next weight.
    always @(negedge clk) begin
      if (!rst_n) begin
        exp_addr <= 0;
        byte_q.delete();
      end else begin
        if (wr_en_s[g]) begin
          if (byte_q.size() == 0) begin
            chk($sformatf("write_without_read_dut%0d", g), 32'd0, 32'd1);
          end else begin
            chk($sformatf("wr_addr_dut%0d", g), 32'(wr_addr_s[g]), exp_addr);
            chk($sformatf("wr_data_dut%0d", g), 32'(wr_data_s[g]), 32'(f_model(byte_q[0], SS)));
            if (wr_ready_s[g]) begin
              wlog[g][wr_addr_s[g]] <= wr_data_s[g];
              wr_cnt[g] <= wr_cnt[g] + 1;
              void'(byte_q.pop_front());
              exp_addr <= exp_addr + 1;
            end
          end
        end
        if (done_s[g]) begin
          chk($sformatf("done_after_all_writes_dut%0d", g), exp_addr, NW);
          done_cnt[g] <= done_cnt[g] + 1;
          exp_addr <= 0;
        end
      end
    end
  end

  // One init run on instance g; cycle k is the period after edge k-1, edge 0 samples start.
  task automatic run(input int g, input int exp_dones, input int budget,
                     input int stall_at, input int stall_len,
                     input int pulse_a, input int pulse_b,
                     input int hold_lo, input int hold_hi, input int rst_at,
                     output int d1, output int d2);
    int seen;
    seen = 0;
    d1 = 0;
    d2 = 0;
    @(posedge clk); #1 start_s[g] = 1'b1;
    @(posedge clk); #1 start_s[g] = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      start_s[g]    = (k == pulse_a) || (k == pulse_b) || (k >= hold_lo && k <= hold_hi);
      wr_ready_s[g] = !(k >= stall_at && k < stall_at + stall_len);
      if (k == rst_at) begin
        #2 rst_n = 1'b0;
        #1 chk_zero(0, "async_reset_dut0");
        chk_zero(1, "async_reset_dut1");
      end
      @(negedge clk);
      if (k == 1) begin
        chk("busy_cycle1", 32'(busy_s[g]), 32'd1);
        chk("rnd_read_cycle1", 32'(rnd_read_s[g]), 32'd1);
      end
      if (stall_len > 0 && k == stall_at + 2) begin
        chk("stall_wr_en", 32'(wr_en_s[g]), 32'd1);
        chk("stall_wr_addr", 32'(wr_addr_s[g]), 32'd1);
      end
      if (hold_hi > 0 && k == hold_hi) begin
        chk("idle_between_runs_busy", 32'(busy_s[g]), 32'd0);
        chk("idle_between_runs_addr", 32'(wr_addr_s[g]), 32'd0);
      end
      if (done_s[g]) begin
        seen++;
        if (seen == 1) d1 = k;
        else d2 = k;
      end
      @(posedge clk); #1;
      if (k == rst_at) rst_n = 1'b1;
      if (exp_dones > 0 && seen >= exp_dones) break;
    end
    chk($sformatf("done_pulses_dut%0d", g), seen, exp_dones);
    start_s[g]    = 1'b0;
    wr_ready_s[g] = 1'b1;
  endtask

  initial begin
    int d1, d2, r0, w0, c0;
    logic [7:0] lf;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      start_s[g]    = 1'b0;
      wr_ready_s[g] = 1'b1;
    end
    src_mem[0][0] = 8'h80; src_mem[0][1] = 8'hFF;
    src_mem[0][2] = 8'h00; src_mem[0][3] = 8'h7F;
    for (int i = 4; i < 256; i++) src_mem[0][i] = 8'((i * 37) & 255);
    src_mem[1][0] = 8'hFF; src_mem[1][1] = 8'h00;
    lf = 8'h01;
    for (int i = 2; i < 256; i++) begin
      src_mem[1][i] = lf;
      lf = f_lfsr_next(lf);
    end

    // Reset values, during and after reset with no start.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero(0, "in_reset_dut0");
    chk_zero(1, "in_reset_dut1");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero(0, "post_reset_dut0");
    chk_zero(1, "post_reset_dut1");

    // Mapping, 4 weights, no scaling.
    r0 = rd_cnt[0]; w0 = wr_cnt[0];
    run(0, 1, 60, 0, 0, 0, 0, -1, -2, 0, d1, d2);
    chk("map_done_cycle", d1, 13);
    chk("map_reads", rd_cnt[0] - r0, 4);
    chk("map_writes", wr_cnt[0] - w0, 4);
    chk("map_w0", 32'(wlog[0][0]), 32'h0000);
    chk("map_w1", 32'(wlog[0][1]), 32'h007F);
    chk("map_w2", 32'(wlog[0][2]), 32'hFF80);
    chk("map_w3", 32'(wlog[0][3]), 32'hFFFF);

    // Backpressure on the second write for 5 cycles.
    r0 = rd_cnt[0];
    run(0, 1, 60, 6, 5, 0, 0, -1, -2, 0, d1, d2);
    chk("stall_done_cycle", d1, 18);
    chk("stall_reads", rd_cnt[0] - r0, 4);

    // start pulses while busy are ignored.
    r0 = rd_cnt[0];
    run(0, 1, 60, 0, 0, 4, 9, -1, -2, 0, d1, d2);
    chk("busy_start_done_cycle", d1, 13);
    chk("busy_start_reads", rd_cnt[0] - r0, 4);

    // start held through DONE launches a second run.
    r0 = rd_cnt[0]; w0 = wr_cnt[0];
    run(0, 2, 60, 0, 0, 0, 0, 12, 14, 0, d1, d2);
    chk("held_first_done", d1, 13);
    chk("held_second_done", d2, 27);
    chk("held_reads", rd_cnt[0] - r0, 8);
    chk("held_writes", wr_cnt[0] - w0, 8);

    // Scaled run on 64 weights, reset while weight 20 is in flight.
    r0 = rd_cnt[1]; w0 = wr_cnt[1]; c0 = done_cnt[1];
    run(1, 0, 70, 0, 0, 0, 0, -1, -2, 62, d1, d2);
    chk("scale_w0", 32'(wlog[1][0]), 32'h07F0);
    chk("scale_w1", 32'(wlog[1][1]), 32'hF800);
    chk("abort_reads", rd_cnt[1] - r0, 21);
    chk("abort_writes", wr_cnt[1] - w0, 20);
    chk("abort_no_done", done_cnt[1] - c0, 0);

    // Full LFSR-driven run after the abort.
    r0 = rd_cnt[1]; w0 = wr_cnt[1];
    run(1, 1, 250, 0, 0, 0, 0, -1, -2, 0, d1, d2);
    chk("full_done_cycle", d1, 193);
    chk("full_reads", rd_cnt[1] - r0, 64);
    chk("full_writes", wr_cnt[1] - w0, 64);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
